// File: rtl/ppu_oam_dma.sv
// Sprite DMA engine behind CPU register $4014: copies one 256-byte page into
// OAMDATA through the ordinary CPU bus path, halting the CPU while it runs.
module ppu_oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter logic [15:0] OAMDATA_ADDR = 16'h2004
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [15:0] cpu_a_in,
    input  logic [7:0]  cpu_d_in,
    input  logic        cpu_r_nw_in,
    input  logic [7:0]  mem_d_in,
    output logic        active_out,
    output logic [15:0] cpu_a_out,
    output logic [7:0]  cpu_d_out,
    output logic        cpu_r_nw_out
);

    typedef enum logic [1:0] {
        S_READY,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  page, page_nxt;
    logic [7:0]  idx, idx_nxt;
    logic [7:0]  data, data_nxt;
    logic        active_nxt;
    logic [15:0] a_nxt;
    logic [7:0]  d_nxt;
    logic        r_nw_nxt;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state        <= S_READY;
            page         <= 8'h00;
            idx          <= 8'h00;
            data         <= 8'h00;
            active_out   <= 1'b0;
            cpu_a_out    <= 16'h0000;
            cpu_d_out    <= 8'h00;
            cpu_r_nw_out <= 1'b1;
        end else begin
            state        <= state_nxt;
            page         <= page_nxt;
            idx          <= idx_nxt;
            data         <= data_nxt;
            active_out   <= active_nxt;
            cpu_a_out    <= a_nxt;
            cpu_d_out    <= d_nxt;
            cpu_r_nw_out <= r_nw_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        page_nxt  = page;
        idx_nxt   = idx;
        data_nxt  = data;

        // CPU bus inputs are only looked at while idle, so a mid-transfer
        // write to $4014 can neither retrigger nor change the page.
        case (state)
            S_READY: begin
                if (cpu_a_in == DMA_REG_ADDR && !cpu_r_nw_in) begin
                    page_nxt  = cpu_d_in;
                    idx_nxt   = 8'h00;
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                data_nxt  = mem_d_in;
                state_nxt = S_WRITE;
            end
            S_WRITE: begin
                if (idx == 8'hFF) begin
                    state_nxt = S_DONE;
                end else begin
                    idx_nxt   = idx + 8'h01;
                    state_nxt = S_READ;
                end
            end
            default: state_nxt = S_READY;
        endcase

        // Outputs are decoded from the next state and registered, so the bus
        // sees clean values for the whole cycle.
        active_nxt = 1'b0;
        a_nxt      = 16'h0000;
        d_nxt      = 8'h00;
        r_nw_nxt   = 1'b1;
        case (state_nxt)
            S_READ: begin
                active_nxt = 1'b1;
                a_nxt      = {page_nxt, idx_nxt};
            end
            S_WRITE: begin
                active_nxt = 1'b1;
                a_nxt      = OAMDATA_ADDR;
                d_nxt      = data_nxt;
                r_nw_nxt   = 1'b0;
            end
            S_DONE:  active_nxt = 1'b1;
            default: active_nxt = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_ppu_oam_dma.sv
// Randomised bench for ppu_oam_dma: a cycle-indexed transfer model is checked
// against the DUT bus outputs on every falling edge.
module tb_ppu_oam_dma;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [15:0] cpu_a_in;
    logic [7:0]  cpu_d_in;
    logic        cpu_r_nw_in;
    logic [7:0]  mem_d_in;
    logic        active_out;
    logic [15:0] cpu_a_out;
    logic [7:0]  cpu_d_out;
    logic        cpu_r_nw_out;

    int errors = 0;
    int checks = 0;

    logic [7:0] salt = 8'h00;

    ppu_oam_dma dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .cpu_a_in     (cpu_a_in),
        .cpu_d_in     (cpu_d_in),
        .cpu_r_nw_in  (cpu_r_nw_in),
        .mem_d_in     (mem_d_in),
        .active_out   (active_out),
        .cpu_a_out    (cpu_a_out),
        .cpu_d_out    (cpu_d_out),
        .cpu_r_nw_out (cpu_r_nw_out)
    );

    always #5 clk_in = ~clk_in;

    // Memory returns a byte derived from the low address byte.
    assign mem_d_in = cpu_a_out[7:0] ^ 8'h5A ^ salt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a transfer is 513 cycles numbered k = 0..512. Even k < 512 reads
    // {page, k/2}, odd k writes that byte to $2004, k = 512 is the idle tail.
    bit         m_active = 1'b0;
    int         m_k = 0;
    logic [7:0] m_page = 8'h00;
    logic [7:0] m_salt = 8'h00;

    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            m_active = 1'b0;
            m_k      = 0;
        end else if (m_active) begin
            if (m_k == 512) m_active = 1'b0;
            else            m_k++;
        end else if (cpu_a_in == 16'h4014 && !cpu_r_nw_in) begin
            m_active = 1'b1;
            m_k      = 0;
            m_page   = cpu_d_in;
            m_salt   = salt;
        end
    end

    always @(negedge clk_in) begin
        logic [15:0] ea;
        logic        er;
        logic [7:0]  ed;
        logic [7:0]  i8;
        if (!rst_in) begin
            ea = 16'h0000;
            er = 1'b1;
            ed = 8'h00;
            if (m_active && m_k < 512) begin
                i8 = 8'(m_k / 2);
                if (m_k % 2 == 0) begin
                    ea = {m_page, i8};
                end else begin
                    ea = 16'h2004;
                    er = 1'b0;
                    ed = i8 ^ 8'h5A ^ m_salt;
                end
            end
            check("bus_cycle",
                  {7'd0, active_out, cpu_a_out, cpu_r_nw_out, (cpu_r_nw_out ? 8'h00 : cpu_d_out)},
                  {7'd0, m_active, ea, er, ed});
        end
    end

    task automatic drive_noise(input bit allow_trigger);
        cpu_a_in    = ($urandom_range(0, 3) == 0) ? 16'h4014 : 16'($urandom);
        cpu_d_in    = 8'($urandom);
        cpu_r_nw_in = 1'($urandom);
        if (!allow_trigger && cpu_a_in == 16'h4014) cpu_r_nw_in = 1'b1;
    endtask

    task automatic trigger(input logic [7:0] page, input logic [7:0] s);
        @(posedge clk_in);
        #1;
        salt        = s;
        cpu_a_in    = 16'h4014;
        cpu_d_in    = page;
        cpu_r_nw_in = 1'b0;
        @(posedge clk_in);
        #1;
        drive_noise(1'b1);
    endtask

    // Follows one transfer until active_out drops, collecting statistics.
    task automatic measure(input bit retrig, input bit chain, input logic [7:0] chain_page,
                           output int act, output int wr, output logic [15:0] first_a,
                           output logic [7:0] first_wd, output logic [15:0] last_rd,
                           output bit zero_rd);
        bit done = 1'b0;
        act = 0; wr = 0; first_a = 16'h0; first_wd = 8'h0; last_rd = 16'h0; zero_rd = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk_in);
            if (!active_out) begin
                done = 1'b1;
            end else begin
                act++;
                if (act == 1) first_a = cpu_a_out;
                if (act == 2) first_wd = cpu_d_out;
                if (!cpu_r_nw_out) wr++;
                else if (act <= 512) begin
                    last_rd = cpu_a_out;
                    if (cpu_a_out == 16'h0000) zero_rd = 1'b1;
                end
                if (retrig && cpu_a_out == 16'h0240) begin
                    cpu_a_in = 16'h4014; cpu_d_in = 8'h07; cpu_r_nw_in = 1'b0;
                end else begin
                    drive_noise(1'b1);
                end
            end
        end
        if (!done) check("transfer_timeout", 32'd1, 32'd0);
        if (chain) begin
            salt        = 8'($urandom);
            cpu_a_in    = 16'h4014;
            cpu_d_in    = chain_page;
            cpu_r_nw_in = 1'b0;
        end else begin
            drive_noise(1'b0);
        end
    endtask

    initial begin
        int          act, wr;
        logic [15:0] fa, lr;
        logic [7:0]  fw;
        bit          zr;
        bit          seen;
        logic [7:0]  cp;

        rst_in = 1'b1;
        cpu_a_in = 16'h0000; cpu_d_in = 8'h00; cpu_r_nw_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #2;
        check("reset_outputs", {15'd0, active_out, cpu_a_out, cpu_r_nw_out},
              {15'd0, 1'b0, 16'h0000, 1'b1});
        check("reset_d", {24'd0, cpu_d_out}, 32'h0);
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (4) begin @(negedge clk_in); drive_noise(1'b0); end

        // Basic transfer, page 02, unsalted data.
        trigger(8'h02, 8'h00);
        measure(1'b0, 1'b0, 8'h00, act, wr, fa, fw, lr, zr);
        check("basic_active_cycles", act, 513);
        check("basic_writes", wr, 256);
        check("basic_first_addr", {16'd0, fa}, 32'h0200);
        check("basic_first_data", {24'd0, fw}, 32'h5A);
        check("basic_last_read", {16'd0, lr}, 32'h02FF);

        // Non-triggers: read of $4014, write to $4015.
        @(negedge clk_in);
        cpu_a_in = 16'h4014; cpu_d_in = 8'h03; cpu_r_nw_in = 1'b1;
        @(negedge clk_in);
        cpu_a_in = 16'h4015; cpu_d_in = 8'h03; cpu_r_nw_in = 1'b0;
        @(negedge clk_in);
        drive_noise(1'b0);
        seen = 1'b0;
        repeat (6) begin @(negedge clk_in); if (active_out) seen = 1'b1; drive_noise(1'b0); end
        check("non_trigger_idle", {31'd0, seen}, 32'd0);

        // Retrigger mid-transfer is ignored.
        trigger(8'h02, 8'($urandom));
        measure(1'b1, 1'b0, 8'h00, act, wr, fa, fw, lr, zr);
        check("retrig_active_cycles", act, 513);
        check("retrig_last_read", {16'd0, lr}, 32'h02FF);

        // Top page, then back-to-back trigger once active_out falls.
        cp = 8'($urandom_range(1, 254));
        trigger(8'hFF, 8'($urandom));
        measure(1'b0, 1'b1, cp, act, wr, fa, fw, lr, zr);
        check("top_active_cycles", act, 513);
        check("top_last_read", {16'd0, lr}, 32'hFFFF);
        check("top_no_zero_addr", {31'd0, zr}, 32'd0);
        check("top_first_addr", {16'd0, fa}, 32'hFF00);
        measure(1'b0, 1'b0, 8'h00, act, wr, fa, fw, lr, zr);
        check("chain_active_cycles", act, 513);
        check("chain_first_addr", {16'd0, fa}, {16'd0, cp, 8'h00});

        // Reset during the write of idx 80.
        trigger(8'h03, 8'($urandom));
        wr = 0; seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk_in);
            if (active_out && !cpu_r_nw_out) wr++;
            if (wr == 8'h81) seen = 1'b1;
        end
        check("reach_idx80_write", {16'd0, cpu_a_out}, 32'h2004);
        #2 rst_in = 1'b1;
        #1;
        check("async_reset_outputs", {7'd0, active_out, cpu_a_out, cpu_r_nw_out, cpu_d_out},
              {7'd0, 1'b0, 16'h0000, 1'b1, 8'h00});
        @(negedge clk_in);
        rst_in = 1'b0;
        drive_noise(1'b0);
        seen = 1'b0;
        repeat (8) begin @(negedge clk_in); if (active_out || !cpu_r_nw_out) seen = 1'b1; drive_noise(1'b0); end
        check("post_reset_idle", {31'd0, seen}, 32'd0);
        trigger(8'h05, 8'($urandom));
        measure(1'b0, 1'b0, 8'h00, act, wr, fa, fw, lr, zr);
        check("post_reset_active_cycles", act, 513);
        check("post_reset_writes", wr, 256);
        check("post_reset_first_addr", {16'd0, fa}, 32'h0500);
        check("post_reset_last_read", {16'd0, lr}, 32'h05FF);

        repeat (3) @(negedge clk_in);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
